// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the fetch stage.
// Contents: datapath widths, the PC increment, default reset PC / NOP,
// the fetch packet carried by the skid buffer and the IF/ID register,
// and a helper that forces word alignment on a PC.
package fetch_pkg;

  localparam int PC_W   = 32;
  localparam int INST_W = 32;
  localparam logic [PC_W-1:0] PC_INC = 32'd4;

  localparam logic [PC_W-1:0]   DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [INST_W-1:0] DEFAULT_NOP_INST = 32'h0000_0000;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
    logic              valid;
  } fetch_pkt_t;

  // Instructions are word aligned; the low two bits of any target are dropped.
  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
    return {pc[PC_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Signal bundle between the fetch unit and its neighbours.
// Control from downstream: stall, redirect_valid, redirect_pc.
// Instruction memory: curr_pc (address out), fetch_inst (data back, one
// cycle after the address is sampled).
// IF/ID register to decode: if_pc, if_inst, if_valid.
// Modports: master = fetch unit, slave = the surrounding pipeline/memory.
// There is no valid/ready handshake here: stall is a hold request that the
// fetch unit honours on the same edge, and redirect_valid is a one-edge pulse
// that overrides stall.
interface pc_fetch_unit_if;
  import fetch_pkg::*;

  logic              stall;
  logic              redirect_valid;
  logic [PC_W-1:0]   redirect_pc;
  logic [INST_W-1:0] fetch_inst;
  logic [PC_W-1:0]   curr_pc;
  logic [PC_W-1:0]   if_pc;
  logic [INST_W-1:0] if_inst;
  logic              if_valid;

  modport master (
    input  stall, redirect_valid, redirect_pc, fetch_inst,
    output curr_pc, if_pc, if_inst, if_valid
  );

  modport slave (
    output stall, redirect_valid, redirect_pc, fetch_inst,
    input  curr_pc, if_pc, if_inst, if_valid
  );

endinterface

// File: rtl/pc_fetch_unit_skid.sv
// One-entry skid buffer holding a fetch packet.
// Ports: clk, rst (sync, active-high), clear (flush), load (capture
// load_pkt and mark valid), drain (mark empty), pkt (stored entry).
// Priority: rst/clear > load > drain.
module fetch_skid_buf
  import fetch_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       load,
  input  logic       drain,
  input  fetch_pkt_t load_pkt,
  output fetch_pkt_t pkt
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      pkt.valid <= 1'b0;
    end else if (load) begin
      pkt.pc    <= load_pkt.pc;
      pkt.inst  <= load_pkt.inst;
      pkt.valid <= 1'b1;
    end else if (drain) begin
      pkt.valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch-stage controller in front of a one-cycle registered instruction
// memory. Owns the PC, tags returning instructions with their PC, absorbs
// the read latency under stalls with a one-entry skid buffer, and drives the
// IF/ID register.
// Ports: clk, rst (sync, active-high), bus (pc_fetch_unit_if.master):
//   stall, redirect_valid, redirect_pc in; fetch_inst in from memory;
//   curr_pc out to memory; if_pc / if_inst / if_valid out to decode.
// Edge priority: rst > redirect > stall > normal issue.
module pc_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0]   RESET_PC = DEFAULT_RESET_PC,
  parameter logic [INST_W-1:0] NOP_INST = DEFAULT_NOP_INST
)(
  input logic               clk,
  input logic               rst,
  pc_fetch_unit_if.master   bus
);

  logic [PC_W-1:0] pc_q;
  // Tag for the word arriving on fetch_inst this cycle.
  logic [PC_W-1:0] resp_pc;
  logic            resp_valid;
  fetch_pkt_t      ifid_q;
  fetch_pkt_t      skid_pkt;
  fetch_pkt_t      resp_pkt;

  logic issue;
  logic skid_load;
  logic skid_drain;

  always_comb begin
    issue         = !bus.redirect_valid && !bus.stall;
    // A stall edge clears resp_valid, so the skid can only fill once per stall
    // and resp/skid are never valid together.
    skid_load     = !bus.redirect_valid && bus.stall && resp_valid && !skid_pkt.valid;
    skid_drain    = issue && skid_pkt.valid;
    resp_pkt.pc    = resp_pc;
    resp_pkt.inst  = resp_valid ? bus.fetch_inst : NOP_INST;
    resp_pkt.valid = resp_valid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      resp_pc    <= '0;
      resp_valid <= 1'b0;
      ifid_q.pc    <= '0;
      ifid_q.inst  <= NOP_INST;
      ifid_q.valid <= 1'b0;
    end else if (bus.redirect_valid) begin
      pc_q         <= align_pc(bus.redirect_pc);
      resp_valid   <= 1'b0;
      ifid_q.inst  <= NOP_INST;
      ifid_q.valid <= 1'b0;
    end else if (bus.stall) begin
      // Memory still samples pc_q this edge; that read is discarded.
      resp_valid <= 1'b0;
    end else begin
      resp_pc    <= pc_q;
      resp_valid <= 1'b1;
      pc_q       <= pc_q + PC_INC;
      ifid_q     <= skid_pkt.valid ? skid_pkt : resp_pkt;
    end
  end

  fetch_skid_buf u_skid (
    .clk      (clk),
    .rst      (rst),
    .clear    (bus.redirect_valid),
    .load     (skid_load),
    .drain    (skid_drain),
    .load_pkt (resp_pkt),
    .pkt      (skid_pkt)
  );

  assign bus.curr_pc  = pc_q;
  assign bus.if_pc    = ifid_q.pc;
  assign bus.if_inst  = ifid_q.inst;
  assign bus.if_valid = ifid_q.valid;

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] TB_NOP = 32'h0000_0013;

  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;
  int   inv_err;

  pc_fetch_unit_if bus ();

  pc_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .NOP_INST (TB_NOP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- instruction memory model ----------------
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return addr ^ 32'hC0DE_0000;
  endfunction

  always @(posedge clk) bus.fetch_inst <= mem_word(bus.curr_pc);

  // resp and skid must never both hold a valid instruction.
  always @(negedge clk) begin
    if (!rst && dut.resp_valid && dut.skid_pkt.valid) inv_err++;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.stall = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  // Reset release plus four edges: IF/ID shows PC 8, curr_pc is 16.
  task automatic stream_to_8();
    do_reset();
    repeat (4) step();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    total_cnt++;
    if (bus.curr_pc !== 32'h0) $display("FAIL reset_curr_pc got=%h exp=%h", bus.curr_pc, 32'h0);
    else pass_cnt++;
    total_cnt++;
    if (bus.if_pc !== 32'h0) $display("FAIL reset_if_pc got=%h exp=%h", bus.if_pc, 32'h0);
    else pass_cnt++;
    total_cnt++;
    if (bus.if_inst !== TB_NOP) $display("FAIL reset_if_inst got=%h exp=%h", bus.if_inst, TB_NOP);
    else pass_cnt++;
    total_cnt++;
    if (bus.if_valid !== 1'b0) $display("FAIL reset_if_valid got=%b exp=0", bus.if_valid);
    else pass_cnt++;
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc;
    do_reset();
    step();  // E1: first issue
    total_cnt++;
    if (bus.if_valid !== 1'b0) $display("FAIL stream_e1_valid got=%b exp=0", bus.if_valid);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      step();
      exp_pc = 32'(i * 4);
      total_cnt++;
      if (bus.if_valid !== 1'b1 || bus.if_pc !== exp_pc || bus.if_inst !== mem_word(exp_pc))
        $display("FAIL stream_%0d got=%b/%h/%h exp=1/%h/%h", i, bus.if_valid, bus.if_pc,
                 bus.if_inst, exp_pc, mem_word(exp_pc));
      else pass_cnt++;
    end
  endtask

  task automatic test_stall_one();
    logic [31:0] exp_seq [4] = '{32'h8, 32'hC, 32'h10, 32'h14};
    stream_to_8();
    bus.stall = 1'b1;
    step();
    bus.stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (bus.if_valid !== 1'b1 || bus.if_pc !== exp_seq[i] || bus.if_inst !== mem_word(exp_seq[i]))
        $display("FAIL stall1_%0d got=%b/%h/%h exp=1/%h/%h", i, bus.if_valid, bus.if_pc,
                 bus.if_inst, exp_seq[i], mem_word(exp_seq[i]));
      else pass_cnt++;
      step();
    end
  endtask

  task automatic test_stall_five();
    logic [31:0] exp_pc;
    stream_to_8();
    bus.stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      total_cnt++;
      if (bus.if_pc !== 32'h8 || bus.if_valid !== 1'b1 || bus.curr_pc !== 32'h10)
        $display("FAIL stall5_hold_%0d got=%h/%b/%h exp=8/1/10", i, bus.if_pc, bus.if_valid,
                 bus.curr_pc);
      else pass_cnt++;
    end
    bus.stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      exp_pc = 32'hC + 32'(i * 4);
      total_cnt++;
      if (bus.if_valid !== 1'b1 || bus.if_pc !== exp_pc || bus.if_inst !== mem_word(exp_pc))
        $display("FAIL stall5_resume_%0d got=%b/%h/%h exp=1/%h/%h", i, bus.if_valid, bus.if_pc,
                 bus.if_inst, exp_pc, mem_word(exp_pc));
      else pass_cnt++;
    end
  endtask

  task automatic test_redirect(input logic [31:0] target, input logic [31:0] exp0,
                               input logic [31:0] exp1);
    stream_to_8();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = target;
    step();
    bus.redirect_valid = 1'b0;
    total_cnt++;
    if (bus.if_valid !== 1'b0 || bus.if_inst !== TB_NOP)
      $display("FAIL redir_%h_flush0 got=%b/%h exp=0/%h", target, bus.if_valid, bus.if_inst, TB_NOP);
    else pass_cnt++;
    step();
    total_cnt++;
    if (bus.if_valid !== 1'b0)
      $display("FAIL redir_%h_flush1 got=%b exp=0", target, bus.if_valid);
    else pass_cnt++;
    step();
    total_cnt++;
    if (bus.if_valid !== 1'b1 || bus.if_pc !== exp0 || bus.if_inst !== mem_word(exp0))
      $display("FAIL redir_%h_t0 got=%b/%h/%h exp=1/%h/%h", target, bus.if_valid, bus.if_pc,
               bus.if_inst, exp0, mem_word(exp0));
    else pass_cnt++;
    step();
    total_cnt++;
    if (bus.if_valid !== 1'b1 || bus.if_pc !== exp1 || bus.if_inst !== mem_word(exp1))
      $display("FAIL redir_%h_t1 got=%b/%h/%h exp=1/%h/%h", target, bus.if_valid, bus.if_pc,
               bus.if_inst, exp1, mem_word(exp1));
    else pass_cnt++;
  endtask

  task automatic test_redirect_stall();
    stream_to_8();
    bus.stall = 1'b1;
    step();  // skid now holds PC 12
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h80;
    step();
    bus.redirect_valid = 1'b0;
    total_cnt++;
    if (bus.if_valid !== 1'b0 || bus.curr_pc !== 32'h80 || dut.skid_pkt.valid !== 1'b0)
      $display("FAIL redir_stall_flush got=%b/%h/%b exp=0/80/0", bus.if_valid, bus.curr_pc,
               dut.skid_pkt.valid);
    else pass_cnt++;
    bus.stall = 1'b0;
    step();
    step();
    total_cnt++;
    if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h80)
      $display("FAIL redir_stall_target got=%b/%h exp=1/80", bus.if_valid, bus.if_pc);
    else pass_cnt++;
  endtask

  task automatic test_reset_in_stall();
    stream_to_8();
    bus.stall = 1'b1;
    step();
    step();
    rst = 1'b1;
    step();
    total_cnt++;
    if (bus.curr_pc !== 32'h0 || bus.if_pc !== 32'h0 || bus.if_inst !== TB_NOP ||
        bus.if_valid !== 1'b0 || dut.skid_pkt.valid !== 1'b0)
      $display("FAIL rst_in_stall got=%h/%h/%h/%b/%b exp=0/0/%h/0/0", bus.curr_pc, bus.if_pc,
               bus.if_inst, bus.if_valid, dut.skid_pkt.valid, TB_NOP);
    else pass_cnt++;
    rst = 1'b0;
    bus.stall = 1'b0;
    step();
    step();
    total_cnt++;
    if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h0 || bus.if_inst !== mem_word(32'h0))
      $display("FAIL rst_in_stall_restart got=%b/%h exp=1/0", bus.if_valid, bus.if_pc);
    else pass_cnt++;
  endtask

  task automatic test_invariant();
    total_cnt++;
    if (inv_err !== 0) $display("FAIL skid_resp_invariant violations=%0d exp=0", inv_err);
    else pass_cnt++;
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    inv_err = 0;
    rst = 1'b1;
    bus.stall = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    test_reset();
    test_stream();
    test_stall_one();
    test_stall_five();
    test_redirect(32'h40, 32'h40, 32'h44);
    test_redirect(32'h43, 32'h40, 32'h44);
    test_redirect(32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'hFFFF_FFFC);
    // Wraparound: one more edge after FFC must show 0.
    step();
    total_cnt++;
    if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h0)
      $display("FAIL pc_wrap got=%b/%h exp=1/0", bus.if_valid, bus.if_pc);
    else pass_cnt++;
    test_redirect_stall();
    test_reset_in_stall();
    test_invariant();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
